// File: rtl/pwm_controller.sv
// PWM channel controller: period counter, active period/duty registers and a
// one-deep config shadow that is applied only at a period boundary.
// Optional feature macro: PWM_DEADTIME_EN adds dt_in and pwm_n_out with
// rising-edge dead-time insertion on both outputs.
module pwm_controller #(
   parameter int unsigned N    = 10
`ifdef PWM_DEADTIME_EN
   ,
   parameter int unsigned DT_W = 4
`endif
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   input  logic         cfg_valid,
   output logic         cfg_ready,
   input  logic [N-1:0] period_in,
   input  logic [N-1:0] duty_in,
`ifdef PWM_DEADTIME_EN
   input  logic [DT_W-1:0] dt_in,
   output logic            pwm_n_out,
`endif
   output logic         pwm_out,
   output logic         period_done,
   output logic         busy
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e       state_q, state_d;
   logic [N-1:0] cnt_q, cnt_d;
   logic [N-1:0] per_q, per_d;
   logic [N-1:0] duty_q, duty_d;
   logic [N-1:0] sh_per_q, sh_per_d;
   logic [N-1:0] sh_duty_q, sh_duty_d;
   logic         pending_q, pending_d;
   logic         raw_d;
   logic         xfer;
   logic         wrap;

`ifdef PWM_DEADTIME_EN
   logic [DT_W-1:0] dt_q, dt_d;
   logic [DT_W-1:0] sh_dt_q, sh_dt_d;
   logic [DT_W-1:0] dtc_q, dtc_d;   // cycles the raw level has been stable, saturating
   logic            raw_q;
   logic            pwm_q, pwm_d;
   logic            pwm_n_q, pwm_n_d;
`else
   logic            pwm_q;
`endif

   assign xfer        = cfg_valid && !pending_q;
   assign wrap        = (state_q != StIdle) && (cnt_q == per_q);
   assign cfg_ready   = !pending_q;
   assign period_done = wrap;
   assign busy        = (state_q != StIdle);
   assign pwm_out     = pwm_q;
`ifdef PWM_DEADTIME_EN
   assign pwm_n_out   = pwm_n_q;
`endif

   // Next-state: FSM, counter, config handshake, boundary load and output compare
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      per_d     = per_q;
      duty_d    = duty_q;
      sh_per_d  = sh_per_q;
      sh_duty_d = sh_duty_q;
      pending_d = pending_q;
`ifdef PWM_DEADTIME_EN
      dt_d      = dt_q;
      sh_dt_d   = sh_dt_q;
`endif

      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            // Idle config goes straight to the active registers
            if (xfer) begin
               per_d  = period_in;
               duty_d = duty_in;
`ifdef PWM_DEADTIME_EN
               dt_d   = dt_in;
`endif
            end
            if (enable) begin
               state_d = StRun;
               if (pending_q) begin
                  per_d     = sh_per_q;
                  duty_d    = sh_duty_q;
                  pending_d = 1'b0;
`ifdef PWM_DEADTIME_EN
                  dt_d      = sh_dt_q;
`endif
               end
            end
         end
         StRun, StDrain: begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            // Load uses the old pending flag, so a same-cycle transfer waits a period
            if (wrap && pending_q) begin
               per_d     = sh_per_q;
               duty_d    = sh_duty_q;
               pending_d = 1'b0;
`ifdef PWM_DEADTIME_EN
               dt_d      = sh_dt_q;
`endif
            end
            if (xfer) begin
               sh_per_d  = period_in;
               sh_duty_d = duty_in;
               pending_d = 1'b1;
`ifdef PWM_DEADTIME_EN
               sh_dt_d   = dt_in;
`endif
            end
            if (state_q == StRun) begin
               if (!enable) state_d = wrap ? StIdle : StDrain;
            end else begin
               if (enable)    state_d = StRun;
               else if (wrap) state_d = StIdle;
            end
            if (state_d == StIdle) cnt_d = '0;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase

      // Output register is loaded from the next count so it aligns with cnt
      raw_d = (state_d != StIdle) && (cnt_d < duty_d);

`ifdef PWM_DEADTIME_EN
      if (raw_d != raw_q)   dtc_d = '0;
      else if (&dtc_q)      dtc_d = dtc_q;
      else                  dtc_d = dtc_q + 1'b1;
      pwm_d   = raw_d && (dtc_d >= dt_d);
      pwm_n_d = (state_d != StIdle) && !raw_d && (dtc_d >= dt_d);
`endif
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         per_q     <= '0;
         duty_q    <= '0;
         sh_per_q  <= '0;
         sh_duty_q <= '0;
         pending_q <= 1'b0;
         pwm_q     <= 1'b0;
`ifdef PWM_DEADTIME_EN
         dt_q      <= '0;
         sh_dt_q   <= '0;
         dtc_q     <= '0;
         raw_q     <= 1'b0;
         pwm_n_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         per_q     <= per_d;
         duty_q    <= duty_d;
         sh_per_q  <= sh_per_d;
         sh_duty_q <= sh_duty_d;
         pending_q <= pending_d;
`ifdef PWM_DEADTIME_EN
         dt_q      <= dt_d;
         sh_dt_q   <= sh_dt_d;
         dtc_q     <= dtc_d;
         raw_q     <= raw_d;
         pwm_q     <= pwm_d;
         pwm_n_q   <= pwm_n_d;
`else
         pwm_q     <= raw_d;
`endif
      end
   end

endmodule
